npc_lsu: RTL and testbench

Load/store unit for the NPC core: the initiator side of the data-memory interface. It accepts one load or store from the execute stage, drives a word-aligned request with byte write mask to the data-memory responder through a valid/ready handshake, waits for the response, then returns sign- or zero-extended load data (or a store acknowledge) to write-back. It sits between EXU and the data-memory model/bus, with one transaction outstanding at a time.

---
 rtl/npc_lsu_if.sv | 33 +++
 rtl/npc_lsu.sv | 62 ++++++
 tb/tb_npc_lsu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/npc_lsu_if.sv
// npc_lsu_if: EXU-side op/completion and data-memory request/response signals of the LSU.
interface npc_lsu_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wen;
  logic [1:0]            in_size;
  logic                  in_unsigned;
  logic [DATA_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic                  out_err;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    input  in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output in_ready, out_valid, out_rdata, out_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
  modport slave (
    output in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  in_ready, out_valid, out_rdata, out_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/npc_lsu.sv
// npc_lsu: single-outstanding load/store unit driving a word-aligned valid/ready data-memory port.
module npc_lsu #(parameter int DATA_WIDTH = 32) (
  input logic       clk,
  input logic       rst,
  npc_lsu_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3;
  logic [1:0]            state, size, off;
  logic                  wen, uns, mis;
  logic [DATA_WIDTH-1:0] wd, sh, ld;
  logic [3:0]            mask;
  always_comb begin
    mis = bus.in_size == 2'b11 || (bus.in_size == 2'b01 && bus.in_addr[0]) ||
          (bus.in_size == 2'b10 && bus.in_addr[1:0] != 2'b00);
    wd = bus.in_size == 2'b00 ? {4{bus.in_wdata[7:0]}} :
         bus.in_size == 2'b01 ? {2{bus.in_wdata[15:0]}} : bus.in_wdata;
    mask = !bus.in_wen ? 4'b0000 :
           bus.in_size == 2'b00 ? 4'b0001 << bus.in_addr[1:0] :
           bus.in_size == 2'b01 ? 4'b0011 << bus.in_addr[1:0] : 4'b1111;
    sh = bus.mem_rdata >> {off, 3'b000};
    ld = size == 2'b00 ? {{(DATA_WIDTH-8){~uns & sh[7]}}, sh[7:0]} :
         size == 2'b01 ? {{(DATA_WIDTH-16){~uns & sh[15]}}, sh[15:0]} : sh;
  end
  assign bus.in_ready      = state == IDLE && !rst;
  assign bus.out_valid     = state == DONE;
  assign bus.mem_req_valid = state == REQ;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      size          <= 2'b00;
      off           <= 2'b00;
      wen           <= 1'b0;
      uns           <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wen   <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= 4'b0000;
      bus.out_rdata <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        state         <= mis ? DONE : REQ;
        size          <= bus.in_size;
        off           <= bus.in_addr[1:0];
        wen           <= bus.in_wen;
        uns           <= bus.in_unsigned;
        bus.mem_addr  <= {bus.in_addr[DATA_WIDTH-1:2], 2'b00};
        bus.mem_wen   <= bus.in_wen;
        bus.mem_wdata <= wd;
        bus.mem_wmask <= mask;
        bus.out_err   <= mis;
        if (mis) bus.out_rdata <= '0;
      end
      if (state == REQ && bus.mem_req_ready) state <= RESP;
      if (state == RESP && bus.mem_resp_valid) begin
        state         <= DONE;
        bus.out_rdata <= wen ? '0 : ld;
      end
      if (state == DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: directed ops with a queue scoreboard checked by an independent completion monitor.
module tb_npc_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t q[$];
  npc_lsu_if #(.DATA_WIDTH(32)) bus ();
  npc_lsu #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out_valid: got out_valid=1 expected no completion at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_rdata", bus.out_rdata, e.rdata);
        chk("sb_err", {31'd0, bus.out_err}, {31'd0, e.err});
      end
    end
  end
  task automatic run_op(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int rdly, input int ddly, input logic [31:0] e_addr,
                        input logic [31:0] e_wdata, input logic [3:0] e_mask,
                        input logic [31:0] e_rdata, input logic e_err);
    @(negedge clk);
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.in_wen = wen; bus.in_size = size; bus.in_unsigned = uns;
    bus.in_addr = addr; bus.in_wdata = wdata;
    q.push_back('{e_rdata, e_err});
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_addr = 32'hFFFF_FFFF; bus.in_wdata = 32'h5A5A_5A5A;
    if (e_err) begin
      chk("err_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("err_out_cycle1", {31'd0, bus.out_valid}, 32'd1);
      @(negedge clk);
      chk("err_pulse_end", {31'd0, bus.out_valid}, 32'd0);
      chk("err_never_req", {31'd0, bus.mem_req_valid}, 32'd0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        chk("req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("req_addr", bus.mem_addr, e_addr);
        chk("req_wen", {31'd0, bus.mem_wen}, {31'd0, wen});
        chk("req_wmask", {28'd0, bus.mem_wmask}, {28'd0, e_mask});
        if (wen) chk("req_wdata", bus.mem_wdata, e_wdata);
        chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        if (i < rdly) begin
          bus.in_valid = 1'b1;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < ddly; i++) begin
        chk("resp_wait_no_out", {31'd0, bus.out_valid}, 32'd0);
        chk("resp_wait_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
        @(negedge clk);
      end
      bus.mem_resp_valid = 1'b1; bus.mem_rdata = rdata;
      chk("pre_done_no_out", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
      chk("done_pulse", {31'd0, bus.out_valid}, 32'd1);
      chk("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("pulse_single", {31'd0, bus.out_valid}, 32'd0);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_wen = 1'b0; bus.in_size = 2'b00; bus.in_unsigned = 1'b0;
    bus.in_addr = 32'h0; bus.in_wdata = 32'h0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_rst_out_rdata", bus.out_rdata, 32'd0);
    run_op(1, 2'b00, 0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 32'h0, 0);
    run_op(0, 2'b01, 0, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001, 0);
    run_op(0, 2'b01, 1, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_8001, 0);
    run_op(0, 2'b00, 0, 32'h8000_0001, 32'h0, 32'h0000_7F00, 0, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_007F, 0);
    run_op(0, 2'b10, 0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'h8000_0004, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0);
    run_op(0, 2'b10, 0, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1);
    run_op(1, 2'b01, 0, 32'h8000_0006, 32'h1234_CAFE, 32'h0, 3, 2, 32'h8000_0004, 32'hCAFE_CAFE, 4'b1100, 32'h0, 0);
    run_op(0, 2'b11, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1);
    run_op(0, 2'b01, 1, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1);
    run_op(1, 2'b10, 0, 32'h8000_0010, 32'h0102_0304, 32'h0, 1, 0, 32'h8000_0010, 32'h0102_0304, 4'b1111, 32'h0, 0);
    run_op(0, 2'b00, 0, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 0, 1, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_wen = 1'b1; bus.in_size = 2'b10; bus.in_addr = 32'h8000_0008;
    bus.in_wdata = 32'h1111_2222;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    chk("midrst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
    chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("midrst_mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);
    chk("midrst_out_rdata", bus.out_rdata, 32'd0);
    chk("midrst_out_err", {31'd0, bus.out_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h5555_5555;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("late_resp_no_out", {31'd0, bus.out_valid}, 32'd0);
      chk("late_resp_idle", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
    end
    run_op(0, 2'b01, 0, 32'h8000_000E, 32'h0, 32'h7FFF_0000, 0, 0, 32'h8000_000C, 32'h0, 4'b0000, 32'h0000_7FFF, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
